ysyx_220066_storebuf: RTL and testbench
=======================================

// Module: ysyx_220066_storebuf
// PURPOSE
//  Store buffer sitting directly upstream of the memory write port (ysyx_220066_memwr).
//  Accepts committed stores from the MEM stage via valid/ready and queues them in order.
//  Drains one store per cycle onto the MemWr/addr/MemOp/data write interface.
//  Flags loads that overlap a pending store so the pipeline stalls the load.
// PARAMETERS
//  DEPTH  4  number of queued stores; power of 2, >=2
//  AW     64 address width
//  DW     64 store data width
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      store request valid
//  in_ready   out  1      buffer can accept; equals ~full
//  in_addr    in   AW     store byte address
//  in_MemOp   in   3      000 SB, 001 SH, 010 SW, 011 SD; others are treated as SD
//  in_data    in   DW     store data, already lane-aligned for the write port
//  mem_ready  in   1      write port may take a store this cycle (low = memory stall)
//  MemWr      out  1      write strobe to the write port
//  addr       out  AW     head entry address
//  MemOp      out  3      head entry MemOp
//  data       out  DW     head entry data
//  ld_addr    in   AW     address of the load currently in MEM
//  ld_hazard  out  1      load overlaps a pending store
//  empty      out  1      no pending stores (used by fence/ecall drain)
//  count      out  $clog2(DEPTH)+1  number of pending stores
// BEHAVIOUR
//  - Storage: circular FIFO; rd_ptr/wr_ptr are $clog2(DEPTH)+1 bits (extra wrap bit).
//    empty = (rd_ptr==wr_ptr); full = index bits equal and wrap bits differ.
//  - Push: at posedge when in_valid & in_ready. Writes addr/MemOp/data to mem[wr_ptr] and increments wr_ptr.
//  - Pop: at posedge when MemWr. Increments rd_ptr.
//    MemWr = ~empty & mem_ready (combinational).
//    addr/MemOp/data = mem[rd_ptr idx], valid only while ~empty.
//  - Latency: a store pushed at edge N can first appear with MemWr high in the cycle after edge N.
//    There is no empty-bypass.
//  - Full: in_ready=0 even if a pop occurs in the same cycle (no full pass-through).
//    in_valid while full is held by upstream; it is not dropped.
//  - Simultaneous push+pop when neither full nor empty: both happen; count is unchanged.
//  - Simultaneous push+pop with count==1: the head pops, the new entry becomes the head, count stays 1.
//  - count = wr_ptr - rd_ptr (modular, width $clog2(DEPTH)+1). Wrap-around must be seamless across index rollover.
//  - ld_hazard: OR over valid entries of (entry.addr[AW-1:3] == ld_addr[AW-1:3]).
//    "Valid" means the slot lies between rd_ptr and wr_ptr.
//    - The entry being popped this cycle still counts (conservative).
//    - A store being pushed this cycle does not count.
//    - Match granularity is the 8-byte doubleword, regardless of MemOp.
//  - Reset (async, any time): rd_ptr=wr_ptr=0. Resulting outputs: in_ready=1, MemWr=0, empty=1, count=0, ld_hazard=0.
//    Pending stores are discarded; data RAM contents are not reset.
//  - Reset release: normal operation from the first posedge after deassertion.
//  - Stores are never reordered or merged.
// STRUCTURE
//  - Shared package ysyx_220066_pkg holds:
//    - MemOp constants MEMOP_SB/SH/SW/SD (3'b000..3'b011);
//    - sbuf entry struct {addr, memop, data}.
//  - One sub-module: ysyx_220066_sbuf_fifo.
//    - Parameterised DEPTH/entry-width FIFO: storage plus pointers.
//    - Exposes all entries and a per-slot valid vector for the hazard compare.
//  - The top level holds the handshake glue and the hazard comparator.
// TESTING
//  - Reset: assert rst mid-run with 3 entries queued.
//    Expect, asynchronously: MemWr=0, empty=1, count=0, in_ready=1.
//    After release, no stale store is issued.
//  - Ordering: push SD@0x80000000 data=0x1122334455667788, then SB@0x80000003, with mem_ready=1.
//    Expect MemWr on consecutive cycles in push order with matching addr/MemOp/data.
//  - Full/backpressure: mem_ready=0, push 4 stores.
//    Expect in_ready=0 and count=4. A 5th in_valid stays held.
//    Raise mem_ready for 1 cycle: one pop, then in_ready=1 the next cycle.
//  - Wrap-around: with mem_ready=1, stream 10 stores at 1 per cycle.
//    Expect all 10 issued in order; count<=1 throughout steady state.
//  - Hazard: pending SW@0x80001004.
//    ld_addr=0x80001000 -> ld_hazard=1. ld_addr=0x80001008 -> 0.
//    After that store pops -> 0.
//  - Push+pop at count==1 with mem_ready=1: count stays 1 and the new entry is at the head next cycle.

Source files
------------

// File: rtl/ysyx_220066_pkg.sv
// Shared definitions for the store path: MemOp encodings and the store-buffer entry layout.
package ysyx_220066_pkg;

    localparam logic [2:0] MEMOP_SB = 3'b000;
    localparam logic [2:0] MEMOP_SH = 3'b001;
    localparam logic [2:0] MEMOP_SW = 3'b010;
    localparam logic [2:0] MEMOP_SD = 3'b011;

    localparam int SBUF_AW = 64;
    localparam int SBUF_DW = 64;

    typedef struct packed {
        logic [SBUF_AW-1:0] addr;
        logic [2:0]         memop;
        logic [SBUF_DW-1:0] data;
    } sbuf_entry_t;

endpackage

// File: rtl/ysyx_220066_storebuf_if.sv
// Store-buffer bus: MEM-stage store handshake, write-port drain, load-hazard probe and status.
interface ysyx_220066_storebuf_if #(
    parameter int AW = 64,
    parameter int DW = 64,
    parameter int CW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [2:0]    in_MemOp;
    logic [DW-1:0] in_data;
    logic          mem_ready;
    logic          MemWr;
    logic [AW-1:0] addr;
    logic [2:0]    MemOp;
    logic [DW-1:0] data;
    logic [AW-1:0] ld_addr;
    logic          ld_hazard;
    logic          empty;
    logic [CW-1:0] count;

    modport slave (
        input  in_valid, in_addr, in_MemOp, in_data, mem_ready, ld_addr,
        output in_ready, MemWr, addr, MemOp, data, ld_hazard, empty, count
    );

    modport master (
        output in_valid, in_addr, in_MemOp, in_data, mem_ready, ld_addr,
        input  in_ready, MemWr, addr, MemOp, data, ld_hazard, empty, count
    );
endinterface

// File: rtl/ysyx_220066_sbuf_fifo.sv
// Circular FIFO with wrap-bit pointers; exposes every slot and a per-slot occupancy vector.
module ysyx_220066_sbuf_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 131
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [W-1:0]              din,
    output logic [W-1:0]              head,
    output logic [DEPTH-1:0][W-1:0]   slots,
    output logic [DEPTH-1:0]          slot_vld,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int IW = $clog2(DEPTH);

    logic [IW:0]  wr_ptr;
    logic [IW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (IW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (IW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[IW-1:0]] <= din;
    end

    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[IW-1:0] == wr_ptr[IW-1:0]) && (rd_ptr[IW] != wr_ptr[IW]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[IW-1:0]];

    // A slot is live when its distance ahead of the read index is below the occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        assign slots[g]    = mem[g];
        assign slot_vld[g] = ({1'b0, IW'(g) - rd_ptr[IW-1:0]} < count);
    end

endmodule

// File: rtl/ysyx_220066_storebuf.sv
// Store buffer in front of the memory write port: in-order queue, one drain per cycle,
// and a doubleword-granular overlap check for the load currently in MEM.
module ysyx_220066_storebuf
    import ysyx_220066_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SBUF_AW,
    parameter int DW    = SBUF_DW
) (
    input logic clk,
    input logic rst,
    ysyx_220066_storebuf_if.slave bus
);
    localparam int EW = AW + 3 + DW;

    sbuf_entry_t                din;
    sbuf_entry_t                head_e;
    logic [EW-1:0]              head;
    logic [DEPTH-1:0][EW-1:0]   slots;
    logic [DEPTH-1:0]           slot_vld;
    logic                       empty;
    logic                       full;
    logic                       push;
    logic                       pop;
    logic                       hazard;
    sbuf_entry_t                ent;

    assign din = '{addr: bus.in_addr, memop: bus.in_MemOp, data: bus.in_data};

    // No full pass-through: a pop in the same cycle does not reopen the input.
    assign bus.in_ready = ~full;
    assign push         = bus.in_valid & ~full;
    assign bus.MemWr    = ~empty & bus.mem_ready;
    assign pop          = bus.MemWr;

    ysyx_220066_sbuf_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .din      (din),
        .head     (head),
        .slots    (slots),
        .slot_vld (slot_vld),
        .empty    (empty),
        .full     (full),
        .count    (bus.count)
    );

    assign head_e    = sbuf_entry_t'(head);
    assign bus.addr  = head_e.addr;
    assign bus.MemOp = head_e.memop;
    assign bus.data  = head_e.data;
    assign bus.empty = empty;

    // The entry draining this cycle is still compared; the one being pushed is not yet in a slot.
    always_comb begin
        hazard = 1'b0;
        ent    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent = sbuf_entry_t'(slots[i]);
            if (slot_vld[i] && (ent.addr[AW-1:3] == bus.ld_addr[AW-1:3])) hazard = 1'b1;
        end
    end

    assign bus.ld_hazard = hazard;

endmodule

// File: tb/tb_ysyx_220066_storebuf.sv
// Self-checking bench for the store buffer: directed scenarios plus random traffic vs a queue model.
module tb_ysyx_220066_storebuf;
    import ysyx_220066_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_220066_storebuf_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

    ysyx_220066_storebuf #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] a;
        logic [2:0]  op;
        logic [63:0] d;
    } st_t;

    st_t q[$];
    int  n_cmp;
    int  n_err;
    bit  accepted;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hazard(input logic [63:0] la);
        foreach (q[i]) if (q[i].a[63:3] == la[63:3]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_req(input logic [63:0] a, input logic [2:0] op, input logic [63:0] d);
        bus.in_valid = 1'b1;
        bus.in_addr  = a;
        bus.in_MemOp = op;
        bus.in_data  = d;
    endtask

    task automatic idle_req();
        bus.in_valid = 1'b0;
    endtask

    // Let inputs settle, then compare every output against the queue model.
    task automatic settle(input string tag);
        bit mw;
        #1;
        mw = (q.size() != 0) && bus.mem_ready;
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(q.size() < DEPTH));
        chk({tag, ".empty"},    64'(bus.empty),    64'(q.size() == 0));
        chk({tag, ".count"},    64'(bus.count),    64'(q.size()));
        chk({tag, ".MemWr"},    64'(bus.MemWr),    64'(mw));
        chk({tag, ".hazard"},   64'(bus.ld_hazard), 64'(model_hazard(bus.ld_addr)));
        if (mw) begin
            chk({tag, ".addr"},  bus.addr,         q[0].a);
            chk({tag, ".MemOp"}, 64'(bus.MemOp),   64'(q[0].op));
            chk({tag, ".data"},  bus.data,         q[0].d);
        end
    endtask

    task automatic tick();
        bit  mw, pu;
        st_t e;
        mw = (q.size() != 0) && bus.mem_ready;
        pu = bus.in_valid && (q.size() < DEPTH);
        e  = '{bus.in_addr, bus.in_MemOp, bus.in_data};
        @(posedge clk);
        if (mw) void'(q.pop_front());
        if (pu) q.push_back(e);
        accepted = pu;
        @(negedge clk);
    endtask

    task automatic cycle(input string tag);
        settle(tag);
        tick();
    endtask

    function automatic logic [63:0] pool_addr();
        return 64'h8000_0000 + {55'd0, 6'($urandom_range(0, 15)), 3'd0} + 64'($urandom_range(0, 7));
    endfunction

    initial begin
        n_cmp = 0;
        n_err = 0;
        accepted = 1'b0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_addr   = '0;
        bus.in_MemOp  = '0;
        bus.in_data   = '0;
        bus.mem_ready = 1'b0;
        bus.ld_addr   = '0;
        #1;
        chk("rst0.in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst0.MemWr",    64'(bus.MemWr),    64'd0);
        chk("rst0.empty",    64'(bus.empty),    64'd1);
        chk("rst0.count",    64'(bus.count),    64'd0);
        chk("rst0.hazard",   64'(bus.ld_hazard), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Ordering: SD then SB, drained on consecutive cycles.
        bus.mem_ready = 1'b1;
        set_req(64'h8000_0000, MEMOP_SD, 64'h1122_3344_5566_7788);
        cycle("ord0");
        set_req(64'h8000_0003, MEMOP_SB, 64'h0000_0000_AA00_0000);
        settle("ord1");
        chk("ord.first_MemWr", 64'(bus.MemWr), 64'd1);
        chk("ord.first_addr",  bus.addr, 64'h8000_0000);
        chk("ord.first_data",  bus.data, 64'h1122_3344_5566_7788);
        tick();
        idle_req();
        settle("ord2");
        chk("ord.second_MemWr", 64'(bus.MemWr), 64'd1);
        chk("ord.second_addr",  bus.addr, 64'h8000_0003);
        chk("ord.second_op",    64'(bus.MemOp), 64'(MEMOP_SB));
        tick();
        settle("ord3");
        chk("ord.drained", 64'(bus.empty), 64'd1);
        tick();

        // Full and backpressure.
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_req(64'h8000_0100 + 64'(k * 8), MEMOP_SD, {$urandom, $urandom});
            cycle("fill");
        end
        set_req(64'h8000_0200, MEMOP_SW, 64'h0000_0000_CAFE_F00D);
        settle("full0");
        chk("full.in_ready", 64'(bus.in_ready), 64'd0);
        chk("full.count",    64'(bus.count),    64'd4);
        tick();
        bus.mem_ready = 1'b1;
        settle("full1");
        chk("full.pop_no_passthru", 64'(bus.in_ready), 64'd0);
        chk("full.pop_MemWr",       64'(bus.MemWr),    64'd1);
        tick();
        bus.mem_ready = 1'b0;
        settle("full2");
        chk("full.reopen", 64'(bus.in_ready), 64'd1);
        chk("full.count3", 64'(bus.count),    64'd3);
        tick();
        idle_req();
        settle("full3");
        chk("full.held_taken", 64'(bus.count), 64'd4);
        tick();
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 6; k++) cycle("drain0");

        // Wrap-around streaming.
        for (int k = 0; k < 10; k++) begin
            set_req(64'h8000_0400 + 64'(k * 16), 3'($urandom_range(0, 3)), {$urandom, $urandom});
            settle("wrap");
            if (k > 0) chk("wrap.count_le1", 64'(bus.count <= CW'(1)), 64'd1);
            tick();
        end
        idle_req();
        for (int k = 0; k < 2; k++) cycle("wrap_tail");

        // Load hazard.
        bus.mem_ready = 1'b0;
        set_req(64'h8000_1004, MEMOP_SW, 64'hDEAD_BEEF_0000_0000);
        cycle("hz0");
        idle_req();
        bus.ld_addr = 64'h8000_1000;
        settle("hz1");
        chk("hz.same_dword", 64'(bus.ld_hazard), 64'd1);
        tick();
        bus.ld_addr = 64'h8000_1008;
        settle("hz2");
        chk("hz.next_dword", 64'(bus.ld_hazard), 64'd0);
        tick();
        bus.ld_addr = 64'h8000_1000;
        bus.mem_ready = 1'b1;
        settle("hz3");
        chk("hz.popping_counts", 64'(bus.ld_hazard), 64'd1);
        tick();
        settle("hz4");
        chk("hz.after_pop", 64'(bus.ld_hazard), 64'd0);
        tick();

        // Push and pop together with one entry pending.
        bus.mem_ready = 1'b0;
        set_req(64'h8000_2000, MEMOP_SD, 64'hAAAA_0000_BBBB_1111);
        cycle("pp0");
        bus.mem_ready = 1'b1;
        set_req(64'h8000_2008, MEMOP_SH, 64'h0000_0000_0000_5A5A);
        settle("pp1");
        chk("pp.count_before", 64'(bus.count), 64'd1);
        tick();
        idle_req();
        bus.mem_ready = 1'b0;
        settle("pp2");
        chk("pp.count_after", 64'(bus.count), 64'd1);
        chk("pp.new_head",    bus.addr, 64'h8000_2008);
        tick();

        // Asynchronous reset with three entries queued.
        set_req(64'h8000_3000, MEMOP_SD, 64'h1);
        cycle("rs0");
        set_req(64'h8000_3008, MEMOP_SD, 64'h2);
        cycle("rs1");
        idle_req();
        settle("rs2");
        chk("rs.count3", 64'(bus.count), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("rs.MemWr",    64'(bus.MemWr),    64'd0);
        chk("rs.empty",    64'(bus.empty),    64'd1);
        chk("rs.count",    64'(bus.count),    64'd0);
        chk("rs.in_ready", 64'(bus.in_ready), 64'd1);
        chk("rs.hazard",   64'(bus.ld_hazard), 64'd0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle("rs_post");
            chk("rs.no_stale", 64'(bus.MemWr), 64'd0);
            tick();
        end

        // Random traffic against the queue model.
        begin
            bit pend;
            pend = 1'b0;
            for (int it = 0; it < 400; it++) begin
                if (!pend && ($urandom_range(0, 3) != 0)) begin
                    pend = 1'b1;
                    set_req(pool_addr(), 3'($urandom_range(0, 7)), {$urandom, $urandom});
                end
                bus.in_valid  = pend;
                bus.mem_ready = ((it % 100) < 50) ? ($urandom_range(0, 3) != 0)
                                                  : ($urandom_range(0, 3) == 0);
                bus.ld_addr   = pool_addr();
                cycle("rand");
                if (accepted) pend = 1'b0;
            end
        end
        idle_req();
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 6; k++) cycle("final");
        chk("final.empty", 64'(bus.empty), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
